// File: rtl/router_ingress_arbiter_pkg.sv
// Shared types and helpers for the Router1x3 ingress arbiter.
// Header byte layout is {len[7:2], addr[1:0]}; addr 2'b11 is not a valid router port.
package router_ingress_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned HDR_LEN_LSB = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAR,
    CHK,
    DROP
  } state_e;

  // Payload length field of a header byte.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] h);
    return h[BYTE_W-1:HDR_LEN_LSB];
  endfunction

  // Destination port field of a header byte.
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] h);
    return h[ADDR_W-1:0];
  endfunction

  // Running XOR parity accumulation.
  function automatic logic [BYTE_W-1:0] parity_acc(input logic [BYTE_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_ingress_arbiter_if.sv
// Source-side and router-side signal bundle of the ingress arbiter.
//   master : arbiter view (consumes src_req/src_data/busy/err, drives the rest)
//   slave  : sources + router view
interface router_ingress_arbiter_if #(
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]        src_req;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ack;
  logic                    busy;
  logic                    err;
  logic                    pkt_valid;
  logic [DATA_W-1:0]       data_out;
  logic                    pkt_done;
  logic                    pkt_err;
  logic                    pkt_drop;
  logic [IDX_W-1:0]        pkt_src;

  modport master (
    input  src_req, src_data, busy, err,
    output src_ack, pkt_valid, data_out, pkt_done, pkt_err, pkt_drop, pkt_src
  );

  modport slave (
    output src_req, src_data, busy, err,
    input  src_ack, pkt_valid, data_out, pkt_done, pkt_err, pkt_drop, pkt_src
  );

endinterface

// File: rtl/router_ingress_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
//   req       : request vector
//   ptr       : highest-priority index this round (< N_SRC)
//   gnt_oh    : one-hot grant
//   gnt_idx   : grant index
//   gnt_valid : any request present
module rr_arbiter #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  int               idx;
  logic [IDX_W-1:0] idx_v;

  // Scan offsets 0..N_SRC-1 from ptr; the first hit wins.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(N_SRC)) idx = idx - int'(N_SRC);
      idx_v = IDX_W'(idx);
      if (!gnt_valid && req[idx_v]) begin
        gnt_valid     = 1'b1;
        gnt_idx       = idx_v;
        gnt_oh[idx_v] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_ingress_arbiter.sv
// Shares the Router1x3 ingress among N_SRC sources: round-robin grant per packet,
// streams header+payload honouring busy, appends XOR parity, samples the router
// err flag after parity and reports per-packet status. addr==3 packets are drained
// from the source and dropped without touching the router.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sources (src_req/src_data/src_ack), router (busy/err/pkt_valid/data_out),
//              status (pkt_done/pkt_err/pkt_drop/pkt_src)
module router_ingress_arbiter
  import router_ingress_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC    = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ERR_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  router_ingress_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(ERR_WAIT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_q, rr_d, rr_next;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  par_q, par_d;
  logic               errs_q, errs_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               drop_q, drop_d;
  logic [IDX_W-1:0]   psrc_q, psrc_d;
  logic [N_SRC-1:0]   ack_c;

  logic [N_SRC-1:0]   gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;

  logic [DATA_W-1:0]  src_bytes [N_SRC];
  logic [DATA_W-1:0]  sel_byte;
  logic [DATA_W-1:0]  hdr_byte;

  rr_arbiter #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr (
    .req       (bus.src_req),
    .ptr       (rr_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Per-source byte lanes.
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      src_bytes[i] = bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  assign sel_byte = src_bytes[g_q];
  assign hdr_byte = src_bytes[gnt_idx];
  assign rr_next  = (g_q == IDX_W'(N_SRC - 1)) ? '0 : g_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q     <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      errs_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      drop_q  <= 1'b0;
      psrc_q  <= '0;
    end else begin
      g_q     <= g_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      errs_q  <= errs_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      drop_q  <= drop_d;
      psrc_q  <= psrc_d;
    end
  end

  // Next-state, datapath updates and source acknowledges.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    errs_d  = errs_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    drop_d  = 1'b0;
    psrc_d  = '0;
    ack_c   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          ack_c  = gnt_oh;
          g_d    = gnt_idx;
          rem_d  = hdr_len(BYTE_W'(hdr_byte));
          errs_d = 1'b0;
          if (hdr_addr(BYTE_W'(hdr_byte)) == ADDR_INVALID) begin
            state_d = DROP;
          end else begin
            data_d  = hdr_byte;
            valid_d = 1'b1;
            par_d   = hdr_byte;
            state_d = HDR;
          end
        end
      end

      // Byte on data_out is taken by the router on this edge when busy is low.
      HDR, PLD: begin
        if (!bus.busy) begin
          if (rem_q != '0) begin
            ack_c[g_q] = 1'b1;
            data_d     = sel_byte;
            par_d      = DATA_W'(parity_acc(BYTE_W'(par_q), BYTE_W'(sel_byte)));
            rem_d      = rem_q - LEN_W'(1);
            state_d    = PLD;
          end else begin
            data_d  = par_q;
            valid_d = 1'b0;
            state_d = PAR;
          end
        end
      end

      PAR: begin
        if (!bus.busy) begin
          data_d  = '0;
          cnt_d   = CNT_W'(ERR_WAIT);
          state_d = CHK;
        end
      end

      // Router flags parity errors a few cycles after acceptance; collect them.
      CHK: begin
        errs_d = errs_q | bus.err;
        if (cnt_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          perr_d  = errs_q | bus.err;
          psrc_d  = g_q;
          rr_d    = rr_next;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Drain the payload from the source without involving the router.
      DROP: begin
        if (rem_q != '0) begin
          ack_c[g_q] = 1'b1;
          rem_d      = rem_q - LEN_W'(1);
        end else begin
          done_d  = 1'b1;
          drop_d  = 1'b1;
          psrc_d  = g_q;
          rr_d    = rr_next;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.src_ack   = rst ? '0 : ack_c;
  assign bus.pkt_valid = valid_q;
  assign bus.data_out  = data_q;
  assign bus.pkt_done  = done_q;
  assign bus.pkt_err   = perr_q;
  assign bus.pkt_drop  = drop_q;
  assign bus.pkt_src   = psrc_q;

endmodule
